// File: rtl/serdes_sched_pkg.sv
// Shared types and helpers for the round-robin serializer scheduler.
// Holds the FSM encoding, the ID-width rule and the default block geometry.
package serdes_sched_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      STREAM = 2'd2
   } sched_state_e;

   localparam int DEF_BIT_WIDTH = 32;
   localparam int DEF_N_SAMPLES = 8;
   localparam int DEF_BLK_W     = DEF_BIT_WIDTH * DEF_N_SAMPLES;

   // A single requester still needs a one-bit ID.
   function automatic int id_width(input int n);
      if (n <= 1) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage

// File: rtl/serializer_rr_scheduler_if.sv
// Producer/serializer side bundle of the round-robin scheduler.
// The slave modport is the scheduler; the master modport is its environment.
interface serializer_rr_scheduler_if #(
   parameter int BIT_WIDTH = serdes_sched_pkg::DEF_BIT_WIDTH,
   parameter int N_SAMPLES = serdes_sched_pkg::DEF_N_SAMPLES,
   parameter int N_REQ     = 4
);
   localparam int BLK  = BIT_WIDTH * N_SAMPLES;
   localparam int ID_W = serdes_sched_pkg::id_width(N_REQ);

   logic [N_REQ*BLK-1:0] recv_msg;
   logic [N_REQ-1:0]     recv_val;
   logic [N_REQ-1:0]     recv_rdy;
   logic [BLK-1:0]       ser_msg;
   logic                 ser_val;
   logic                 ser_rdy;
   logic                 mon_val;
   logic                 mon_rdy;
   logic [ID_W-1:0]      cur_id;
   logic                 busy;
   logic                 pkt_done;

   modport master (
      output recv_msg, recv_val, ser_rdy, mon_val, mon_rdy,
      input  recv_rdy, ser_msg, ser_val, cur_id, busy, pkt_done
   );

   modport slave (
      input  recv_msg, recv_val, ser_rdy, mon_val, mon_rdy,
      output recv_rdy, ser_msg, ser_val, cur_id, busy, pkt_done
   );

endinterface

// File: rtl/serializer_rr_scheduler_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// The request vector is rotated so ptr lands on bit 0, then a lowest-set search runs.
module rr_priority_picker #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [ID_W-1:0]  winner,
   output logic             any_valid
);

   localparam logic [ID_W:0] N_REQ_W = (ID_W+1)'(N_REQ);

   logic [2*N_REQ-1:0] dbl_s;
   logic [N_REQ-1:0]   rot_s;
   logic [ID_W-1:0]    off_s;
   logic [ID_W:0]      sum_s;

   // rotate, find lowest set offset, then map the offset back to an absolute index
   always_comb begin
      dbl_s = {req, req} >> ptr;
      rot_s = dbl_s[N_REQ-1:0];
      off_s = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot_s[i]) begin
            off_s = ID_W'(i);
         end else begin
            off_s = off_s;
         end
      end
      sum_s = {1'b0, ptr} + {1'b0, off_s};
      if (sum_s >= N_REQ_W) begin
         sum_s = sum_s - N_REQ_W;
      end else begin
         sum_s = sum_s;
      end
      winner    = sum_s[ID_W-1:0];
      any_valid = |req;
   end

endmodule

// File: rtl/serializer_rr_scheduler.sv
// Shares one serializer among N_REQ block producers with round-robin grants.
// A grant is held until the serializer output has shown N_SAMPLES handshakes.
module serializer_rr_scheduler
   import serdes_sched_pkg::*;
#(
   parameter int BIT_WIDTH = DEF_BIT_WIDTH,
   parameter int N_SAMPLES = DEF_N_SAMPLES,
   parameter int N_REQ     = 4
) (
   input logic                   clk,
   input logic                   reset,
   serializer_rr_scheduler_if.slave bus
);

   localparam int BLK   = BIT_WIDTH * N_SAMPLES;
   localparam int ID_W  = id_width(N_REQ);
   localparam int CNT_W = $clog2(N_SAMPLES) + 1;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);
   localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);

   sched_state_e     state_r;
   sched_state_e     state_s;
   logic [ID_W-1:0]  ptr_r;
   logic [ID_W-1:0]  cur_id_r;
   logic [CNT_W-1:0] cnt_r;
   logic             pkt_done_r;

   logic [ID_W-1:0]  win_s;
   logic             any_s;
   logic             cur_val_s;
   logic             accept_s;
   logic             mon_hs_s;
   logic             last_word_s;
   logic [ID_W-1:0]  next_ptr_s;

   rr_priority_picker #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_picker (
      .req       (bus.recv_val),
      .ptr       (ptr_r),
      .winner    (win_s),
      .any_valid (any_s)
   );

   assign cur_val_s   = bus.recv_val[cur_id_r];
   assign accept_s    = cur_val_s & bus.ser_rdy;
   assign mon_hs_s    = bus.mon_val & bus.mon_rdy;
   assign last_word_s = (cnt_r == LAST_CNT);
   assign next_ptr_s  = (cur_id_r == LAST_ID) ? {ID_W{1'b0}} : (cur_id_r + ID_W'(1));

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (any_s) begin
               state_s = ISSUE;
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: begin
            // a producer withdrawing its block before acceptance forfeits the grant
            if (!cur_val_s) begin
               state_s = IDLE;
            end else if (bus.ser_rdy) begin
               state_s = STREAM;
            end else begin
               state_s = ISSUE;
            end
         end
         STREAM: begin
            if (mon_hs_s && last_word_s) begin
               state_s = IDLE;
            end else begin
               state_s = STREAM;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // grant ID, word counter, arbitration pointer and end-of-packet pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_r      <= '0;
         cur_id_r   <= '0;
         cnt_r      <= '0;
         pkt_done_r <= 1'b0;
      end else begin
         pkt_done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (any_s) begin
                  cur_id_r <= win_s;
               end else begin
                  cur_id_r <= cur_id_r;
               end
            end
            ISSUE: begin
               if (accept_s) begin
                  cnt_r <= '0;
               end else begin
                  cnt_r <= cnt_r;
               end
            end
            STREAM: begin
               if (mon_hs_s && last_word_s) begin
                  cnt_r      <= '0;
                  ptr_r      <= next_ptr_s;
                  pkt_done_r <= 1'b1;
               end else if (mon_hs_s) begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end else begin
                  cnt_r <= cnt_r;
               end
            end
            default: begin
               cnt_r <= '0;
            end
         endcase
      end
   end

   // serializer-facing outputs; only ISSUE exposes a block and a ready
   always_comb begin
      bus.ser_msg  = '0;
      bus.ser_val  = 1'b0;
      bus.recv_rdy = '0;
      bus.busy     = 1'b0;
      case (state_r)
         IDLE: begin
            bus.busy = 1'b0;
         end
         ISSUE: begin
            bus.ser_msg            = bus.recv_msg[int'(cur_id_r)*BLK +: BLK];
            bus.ser_val            = cur_val_s;
            bus.recv_rdy[cur_id_r] = bus.ser_rdy;
            bus.busy               = 1'b1;
         end
         STREAM: begin
            bus.busy = 1'b1;
         end
         default: begin
            bus.busy = 1'b0;
         end
      endcase
   end

   assign bus.cur_id   = cur_id_r;
   assign bus.pkt_done = pkt_done_r;

endmodule
